// File: rtl/player_tick_sequencer_pkg.sv
// Shared types and constants for the player tick sequencer.
// State encoding, collision flag bit positions, default parameters.
package player_tick_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_STEP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_STEP = ST_STEP,
    S_DONE = ST_DONE
  } state_e;

  localparam int COL_LEFT  = 0;
  localparam int COL_BOT   = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_TOP   = 3;

  localparam int FRAME_DIV_DEF   = 1;
  localparam int COL_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF       = 7;

endpackage

// File: rtl/player_tick_sequencer_edge_latch.sv
// Rising-edge detector with a sticky set/clear latch.
// A new edge in the clearing cycle wins, so no press is lost.
module player_tick_sequencer_edge_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  input  logic clr_i,
  output logic q_o
);

  logic prev_q;
  logic lat_q;
  logic lat_d;
  logic rise;

  assign rise  = d_i & ~prev_q;
  assign lat_d = rise | (lat_q & ~clr_i);
  assign q_o   = lat_q;

  // previous-level register and latch state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      lat_q  <= 1'b0;
    end else begin
      prev_q <= d_i;
      lat_q  <= lat_d;
    end
  end

endmodule

// File: rtl/player_tick_sequencer.sv
// Frame-rate scheduler for the player physics step.
// Optional SINGLE_STEP_EN adds step_btn for stepping while paused.
module player_tick_sequencer
  import player_tick_sequencer_pkg::*;
#(
  parameter int FRAME_DIV   = FRAME_DIV_DEF,
  parameter int COL_TIMEOUT = COL_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       jump_btn,
  input  logic       pause,
`ifdef SINGLE_STEP_EN
  input  logic       step_btn,
`endif
  output logic       col_req,
  input  logic       col_ack,
  input  logic [3:0] col_result,
  output logic       sim_step,
  output logic       jump_r,
  output logic [3:0] player_col,
  output logic       busy,
  output logic       overrun,
  output logic       col_timeout
);

  localparam logic [3:0] DIV_LAST =
    4'(FRAME_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(COL_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pcol_q, pcol_d;
  logic             ovr_q, ovr_d;
  logic             cto_q, cto_d;
  logic             jump_lat;
  logic             start;

  player_tick_sequencer_edge_latch u_jump (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (jump_btn),
    .clr_i   (sim_step),
    .q_o     (jump_lat)
  );

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      pcol_q  <= '0;
      ovr_q   <= 1'b0;
      cto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      pcol_q  <= pcol_d;
      ovr_q   <= ovr_d;
      cto_q   <= cto_d;
    end
  end

  // next-state, divider, timeout and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    pcol_d   = pcol_q;
    ovr_d    = ovr_q;
    cto_d    = cto_q;
    start    = 1'b0;
    col_req  = 1'b0;
    sim_step = 1'b0;
    jump_r   = 1'b0;

    if (state_q != S_IDLE && frame_start)
      ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!pause && frame_start) begin
          if (div_q == DIV_LAST) begin
            start = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 4'd1;
          end
        end
`ifdef SINGLE_STEP_EN
        if (pause && step_btn)
          start = 1'b1;
`endif
        if (start)
          state_d = S_REQ;
      end
      S_REQ: begin
        col_req = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        col_req = 1'b1;
        if (col_ack) begin
          pcol_d  = col_result;
          state_d = S_STEP;
        end else if (cnt_q == CNT_LAST) begin
          pcol_d  = '0;
          cto_d   = 1'b1;
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STEP: begin
        sim_step = 1'b1;
        jump_r   = jump_lat;
        pcol_d   = '0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign player_col  = pcol_q;
  assign overrun     = ovr_q;
  assign col_timeout = cto_q;

endmodule

// File: tb/tb_player_tick_sequencer.sv
// Directed bench for player_tick_sequencer.
// Vector table plus hand sequences for timeout, divider, overrun, reset.
module tb_player_tick_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       jump_btn = 1'b0;
  logic       pause = 1'b0;
  logic       col_ack = 1'b0;
  logic [3:0] col_result = 4'd0;
`ifdef SINGLE_STEP_EN
  logic       step_btn = 1'b0;
`endif

  logic       req1, stp1, jr1, bsy1, ovr1, cto1;
  logic [3:0] pc1;
  logic       req3, stp3, jr3, bsy3, ovr3, cto3;
  logic [3:0] pc3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  player_tick_sequencer #(
    .FRAME_DIV(1), .COL_TIMEOUT(64), .CNT_W(7)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .jump_btn(jump_btn),
    .pause(pause),
`ifdef SINGLE_STEP_EN
    .step_btn(step_btn),
`endif
    .col_req(req1), .col_ack(col_ack),
    .col_result(col_result), .sim_step(stp1),
    .jump_r(jr1), .player_col(pc1), .busy(bsy1),
    .overrun(ovr1), .col_timeout(cto1)
  );

  player_tick_sequencer #(
    .FRAME_DIV(3), .COL_TIMEOUT(64), .CNT_W(7)
  ) dut3 (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .jump_btn(jump_btn),
    .pause(pause),
`ifdef SINGLE_STEP_EN
    .step_btn(step_btn),
`endif
    .col_req(req3), .col_ack(col_ack),
    .col_result(col_result), .sim_step(stp3),
    .jump_r(jr3), .player_col(pc3), .busy(bsy3),
    .overrun(ovr3), .col_timeout(cto3)
  );

  typedef struct {
    logic       fs, ack, jb, pz;
    logic [3:0] res;
    logic       req, stp, jr, bsy;
    logic [3:0] pc;
  } vec_t;

  vec_t tv[$];

  task automatic add(
    input logic fs, input logic ack,
    input logic [3:0] res,
    input logic jb, input logic pz,
    input logic req, input logic stp,
    input logic jr, input logic [3:0] pc,
    input logic bsy
  );
    vec_t v;
    v.fs = fs; v.ack = ack; v.res = res;
    v.jb = jb; v.pz = pz;
    v.req = req; v.stp = stp; v.jr = jr;
    v.pc = pc; v.bsy = bsy;
    tv.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    frame_start = 0; col_ack = 0; jump_btn = 0;
    pause = 0; col_result = 0;
    #2 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  int n;
  int nsim;

  initial begin
    // fs ack res jb pz | req stp jr pc bsy
    add(1,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,1,4'h2,0,0, 0,1,0,4'h2,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(0,0,4'h0,1,0, 0,0,0,4'h0,0);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,1,4'h9,0,0, 0,1,1,4'h9,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,1,4'h4,0,0, 0,1,0,4'h4,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(0,1,4'hf,0,0, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,1, 0,0,0,4'h0,0);
    add(0,0,4'h0,1,1, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,1, 0,0,0,4'h0,0);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,1,4'h1,0,0, 0,1,1,4'h1,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,0,4'h0,0,1, 1,0,0,4'h0,1);
    add(0,1,4'h0,0,1, 0,1,0,4'h0,1);
    add(0,0,4'h0,1,0, 0,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);
    add(1,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 1,0,0,4'h0,1);
    add(0,1,4'h6,0,0, 0,1,1,4'h6,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,1);
    add(0,0,4'h0,0,0, 0,0,0,4'h0,0);

    do_reset();
    chk("rst_req", 32'(req1), 0);
    chk("rst_busy", 32'(bsy1), 0);
    chk("rst_step", 32'(stp1), 0);
    chk("rst_pc", 32'(pc1), 0);
    chk("rst_ovr", 32'(ovr1), 0);
    chk("rst_cto", 32'(cto1), 0);

    foreach (tv[i]) begin
      frame_start = tv[i].fs;
      col_ack     = tv[i].ack;
      col_result  = tv[i].res;
      jump_btn    = tv[i].jb;
      pause       = tv[i].pz;
      tick();
      chk($sformatf("v%0d_req", i), 32'(req1), 32'(tv[i].req));
      chk($sformatf("v%0d_stp", i), 32'(stp1), 32'(tv[i].stp));
      chk($sformatf("v%0d_jr", i), 32'(jr1), 32'(tv[i].jr));
      chk($sformatf("v%0d_pc", i), 32'(pc1), 32'(tv[i].pc));
      chk($sformatf("v%0d_bsy", i), 32'(bsy1), 32'(tv[i].bsy));
    end
    frame_start = 0; col_ack = 0; col_result = 0;
    jump_btn = 0; pause = 0;
    chk("tbl_ovr", 32'(ovr1), 0);
    chk("tbl_cto", 32'(cto1), 0);

    // collision unit never answers
    frame_start = 1;
    tick();
    frame_start = 0;
    n = 1;
    while (!stp1 && n < 200) begin
      chk("to_cto_early", 32'(cto1), 0);
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 66);
    chk("to_pc", 32'(pc1), 0);
    chk("to_cto", 32'(cto1), 1);
    repeat (2) tick();
    chk("to_busy", 32'(bsy1), 0);
    repeat (5) tick();
    chk("to_sticky", 32'(cto1), 1);

    // ack in the final timeout cycle wins
    do_reset();
    frame_start = 1;
    tick();
    frame_start = 0;
    repeat (64) tick();
    chk("late_wait", 32'(req1), 1);
    col_ack = 1; col_result = 4'ha;
    tick();
    col_ack = 0; col_result = 0;
    chk("late_stp", 32'(stp1), 1);
    chk("late_pc", 32'(pc1), 32'h a);
    chk("late_cto", 32'(cto1), 0);
    repeat (2) tick();

    // frame_start during WAIT with a slow ack
    frame_start = 1;
    tick();
    frame_start = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      frame_start = (i == 3);
      tick();
    end
    frame_start = 0;
    chk("ovr_set", 32'(ovr1), 1);
    col_ack = 1; col_result = 4'h3;
    tick();
    col_ack = 0; col_result = 0;
    nsim = int'(stp1);
    for (int i = 0; i < 20; i++) begin
      tick();
      nsim += int'(stp1);
    end
    chk("ovr_steps", 32'(nsim), 1);
    chk("ovr_sticky", 32'(ovr1), 1);

    // divide-by-three instance steps on 3rd and 6th frame
    do_reset();
    nsim = 0;
    for (int k = 1; k <= 6; k++) begin
      frame_start = 1;
      tick();
      frame_start = 0;
      tick();
      col_ack = 1; col_result = 4'h8;
      tick();
      col_ack = 0; col_result = 0;
      chk($sformatf("div_f%0d", k), 32'(stp3),
          32'((k == 3) || (k == 6)));
      nsim += int'(stp3);
      repeat (2) tick();
      nsim += int'(stp3);
    end
    chk("div_count", 32'(nsim), 2);

    // asynchronous reset while waiting
    frame_start = 1;
    tick();
    frame_start = 0;
    tick();
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("ar_req", 32'(req1), 1);
    chk("ar_ovr", 32'(ovr1), 1);
    #2 reset_n = 0;
    #1;
    chk("ar_req0", 32'(req1), 0);
    chk("ar_busy0", 32'(bsy1), 0);
    chk("ar_stp0", 32'(stp1), 0);
    @(posedge clk);
    #1 reset_n = 1;
    tick();
    chk("ar_idle", 32'(bsy1), 0);
    chk("ar_ovr0", 32'(ovr1), 0);
    chk("ar_cto0", 32'(cto1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_tick_sequencer.md
Name: player_tick_sequencer

Overview:
Frame-rate scheduler that drives the player physics update.
- On every FRAME_DIV-th frame-start pulse, requests a collision query, waits for the result, then issues a one-cycle step enable to the player datapath.
- Latches the jump button edge so a press between frames is not lost.
- Sits between the VGA timing generator, the tile collision unit and the player module.

Parameters:
FRAME_DIV, 1, number of frame_start pulses per physics step (1..15)
COL_TIMEOUT, 64, clk cycles to wait for col_ack before abandoning the query
CNT_W, 7, width of the timeout counter (must hold COL_TIMEOUT)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
jump_btn  in  1  synchronized, debounced jump button level
pause  in  1  level; while high no new steps start
col_req  out  1  held high until col_ack while querying collision unit
col_ack  in  1  one-cycle pulse, col_result valid same cycle
col_result  in  4  collision flags {top,right,bottom,left}
sim_step  out  1  one-cycle step enable to player datapath
jump_r  out  1  jump request, valid only while sim_step high
player_col  out  4  registered collision flags, valid while sim_step high
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky; frame_start arrived while busy
col_timeout  out  1  sticky; a query timed out

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; frame divider counter 0; jump latch 0; timeout counter 0.
- Jump latch:
  - Set on rising edge of jump_btn (registered previous value).
  - Cleared in the cycle sim_step is asserted, unless a new rising edge occurs in that same cycle; then it stays set.
  - Captures presses during pause.
- Frame divider:
  - Increments on each frame_start seen in IDLE with pause low.
  - When it reaches FRAME_DIV-1, the next such frame_start starts a step and the divider returns to 0.
  - With FRAME_DIV=1, every frame_start starts a step.
- States:
  - IDLE: on qualifying frame_start -> REQ. pause high: frame_start ignored, divider frozen.
  - REQ: col_req=1, timeout counter cleared -> WAIT next cycle.
  - WAIT: col_req stays 1; timeout counter increments.
    - col_ack: latch col_result into player_col -> STEP.
    - Counter reaches COL_TIMEOUT-1 without ack: player_col=0, set col_timeout -> STEP.
    - col_ack in the timeout cycle: ack wins, col_timeout not set.
  - STEP: col_req=0; sim_step=1 for exactly one cycle; jump_r = jump latch value -> DONE.
  - DONE: sim_step=0, player_col cleared to 0 -> IDLE.
- Latency: frame_start to sim_step = 3 cycles when col_ack arrives the cycle after REQ. Minimum 3, maximum COL_TIMEOUT+2.
- frame_start while busy: sets overrun, is not queued, does not advance the divider.
- pause raised mid-sequence: the current sequence completes; pause only gates IDLE.
- col_ack outside WAIT is ignored.
- overrun and col_timeout clear only on reset.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input step_btn (one-cycle pulse). While pause is high in IDLE, step_btn starts a sequence (REQ) ignoring frame_start and the divider. When pause is low, step_btn is ignored.
- Undefined: no step_btn port; behaviour exactly as above.

Decomposition:
- Shared package: state encoding localparams (IDLE, REQ, WAIT, STEP, DONE, 3-bit), collision bit indices (COL_LEFT=0, COL_BOT=1, COL_RIGHT=2, COL_TOP=3), default FRAME_DIV and COL_TIMEOUT.
- One natural sub-module, edge_latch: rising-edge detect plus set/clear latch for jump_btn.
- FSM, divider and timeout counter stay in the top module.

Test Plan:
- Reset, FRAME_DIV=1; frame_start; col_ack with col_result=4'b0010 one cycle after col_req -> sim_step high exactly 3 cycles after frame_start, player_col=4'b0010, jump_r=0, busy returns low 1 cycle later.
- Pulse jump_btn 0->1->0 mid-frame, then frame_start -> jump_r=1 during sim_step. Second frame with no press -> jump_r=0.
- Never ack -> sim_step at cycle COL_TIMEOUT+2 (66 with default 64), player_col=0, col_timeout=1 and stays 1.
- FRAME_DIV=3, 6 frame_starts -> exactly 2 sim_step pulses, on the 3rd and 6th.
- Delay col_ack 10 cycles and pulse frame_start during WAIT -> overrun=1, only one sim_step. Pause high -> frame_starts produce no col_req; jump press during pause is delivered on first step after unpause.
- Assert reset_n low while in WAIT -> col_req, busy and sim_step drop to 0 immediately (asynchronously); after release, state is IDLE and sticky flags are 0.
